// File: rtl/pipe_pkg.sv
// Shared opcode encodings, issue-controller state and opcode decode helpers
// for the ADD/SUB/LOAD pipeline.
package pipe_pkg;

    localparam int OPC_W = 4;
    localparam int RA_W  = 4;

    localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_SUB  = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_LOAD = 4'b0011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    function automatic logic is_writer(input logic [OPC_W-1:0] opcode);
        return (opcode == OPC_ADD) || (opcode == OPC_SUB) || (opcode == OPC_LOAD);
    endfunction

    // LOAD carries a memory address in rs2, so only ADD/SUB depend on it.
    function automatic logic reads_rs2(input logic [OPC_W-1:0] opcode);
        return (opcode == OPC_ADD) || (opcode == OPC_SUB);
    endfunction

endpackage

// File: rtl/wb_shift_pipe.sv
// Fixed-latency delay line of {valid, rd} for in-flight register writes.
// The last stage is the head; it retires the register on the following edge.
module wb_shift_pipe #(
    parameter int DEPTH = 2,
    parameter int RA_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_v,
    input  logic [RA_W-1:0] in_rd,
    output logic            head_v,
    output logic [RA_W-1:0] head_rd,
    output logic            empty
);

    logic [DEPTH-1:0]           vld_pipe;
    logic [DEPTH-1:0][RA_W-1:0] rd_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
        end else begin
            vld_pipe[0] <= in_v;
            rd_pipe[0]  <= in_rd;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
            end
        end
    end

    assign head_v  = vld_pipe[DEPTH-1];
    assign head_rd = rd_pipe[DEPTH-1];
    assign empty   = ~|vld_pipe;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue controller between decode and execute: register scoreboard, hazard
// stall, fixed-latency write-back strobe and a drain/halt handshake.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NREG      = 16,
    parameter int RA_W      = 4,
    parameter int WB_LAT    = 2,
    parameter int MAX_STALL = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             flush,
    input  logic             drain_req,
    output logic             issue,
    output logic             stall,
    output logic             wb_valid,
    output logic [RA_W-1:0]  wb_rd,
    output logic [NREG-1:0]  pending,
    output logic             drained,
    output logic [3:0]       stall_cnt,
    output logic             err
);

    ctrl_state_t     state;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] retire_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] eff_pend;
    logic            writer;
    logic            chk_rs2;
    logic            hazard;
    logic            block;
    logic            head_v;
    logic [RA_W-1:0] head_rd;
    logic            pipe_empty;
    logic [3:0]      cnt_nxt;

    assign writer  = is_writer(id_opcode);
    assign chk_rs2 = reads_rs2(id_opcode);

    // The head entry retires this cycle, so its register reads as free
    // (the register file writes through to the reader).
    always_comb begin
        retire_mask = '0;
        if (head_v) retire_mask[head_rd] = 1'b1;
    end

    assign eff_pend = pend_q & ~retire_mask;
    assign hazard   = writer & (eff_pend[id_rs1] | (chk_rs2 & eff_pend[id_rs2]) | eff_pend[id_rd]);
    assign block    = hazard | (state != RUN);
    assign issue    = id_valid & ~flush & ~block;
    assign stall    = id_valid & ~flush & block;

    always_comb begin
        set_mask = '0;
        if (issue && writer) set_mask[id_rd] = 1'b1;
    end

    wb_shift_pipe #(
        .DEPTH (WB_LAT),
        .RA_W  (RA_W)
    ) u_wb_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_v    (issue & writer),
        .in_rd   (id_rd),
        .head_v  (head_v),
        .head_rd (head_rd),
        .empty   (pipe_empty)
    );

    always_comb begin
        cnt_nxt = 4'd0;
        if (state == RUN && stall) cnt_nxt = (stall_cnt == 4'd15) ? 4'd15 : stall_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            stall_cnt <= 4'd0;
            err       <= 1'b0;
        end else begin
            // Set is applied after clear so a same-cycle reissue keeps the bit.
            pend_q    <= eff_pend | set_mask;
            wb_valid  <= head_v;
            wb_rd     <= head_rd;
            stall_cnt <= cnt_nxt;
            if (state == RUN && cnt_nxt >= 4'(MAX_STALL)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            drained <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state <= RUN;
                    end else if (pipe_empty && pend_q == '0) begin
                        state   <= HALT;
                        drained <= 1'b1;
                    end
                end
                HALT: begin
                    if (!drain_req) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    drained <= 1'b0;
                end
            endcase
        end
    end

    assign pending = pend_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: issue/stall, write-through, WAW,
// drain/halt, asynchronous reset and the stall watchdog.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rd;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        flush;
    logic        drain_req;
    logic        issue;
    logic        stall;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [15:0] pending;
    logic        drained;
    logic [3:0]  stall_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_opcode (id_opcode),
        .id_rd     (id_rd),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .flush     (flush),
        .drain_req (drain_req),
        .issue     (issue),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .pending   (pending),
        .drained   (drained),
        .stall_cnt (stall_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2);
        id_valid  = v;
        id_opcode = op;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; drain_req = 1'b0;
        id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_drained", 32'(drained), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;

        // Independent ADD then SUB
        drv(1, OPC_ADD, 4'd1, 4'd2, 4'd3);
        chk("s1_add_issue", 32'(issue), 32'h1);
        chk("s1_add_stall", 32'(stall), 32'h0);
        step();
        chk("s1_pend_a", 32'(pending), 32'h0002);
        drv(1, OPC_SUB, 4'd4, 4'd5, 4'd6);
        chk("s1_sub_issue", 32'(issue), 32'h1);
        step();
        chk("s1_pend_b", 32'(pending), 32'h0012);
        chk("s1_wb_early", 32'(wb_valid), 32'h0);
        idle();
        step();
        chk("s1_wb1_v", 32'(wb_valid), 32'h1);
        chk("s1_wb1_rd", 32'(wb_rd), 32'h1);
        chk("s1_pend_c", 32'(pending), 32'h0010);
        step();
        chk("s1_wb2_v", 32'(wb_valid), 32'h1);
        chk("s1_wb2_rd", 32'(wb_rd), 32'h4);
        chk("s1_pend_d", 32'(pending), 32'h0000);
        step();
        chk("s1_wb_off", 32'(wb_valid), 32'h0);

        // RAW on r1: one stall, issue on write-through
        drv(1, OPC_ADD, 4'd1, 4'd2, 4'd3);
        chk("s2_add_issue", 32'(issue), 32'h1);
        step();
        drv(1, OPC_ADD, 4'd5, 4'd1, 4'd2);
        chk("s2_raw_stall", 32'(stall), 32'h1);
        chk("s2_raw_noissue", 32'(issue), 32'h0);
        step();
        chk("s2_cnt1", 32'(stall_cnt), 32'h1);
        chk("s2_wt_issue", 32'(issue), 32'h1);
        chk("s2_wt_stall", 32'(stall), 32'h0);
        step();
        chk("s2_cnt0", 32'(stall_cnt), 32'h0);
        chk("s2_wb_rd1", 32'(wb_rd), 32'h1);
        chk("s2_pend", 32'(pending), 32'h0020);
        idle();
        step();
        step();
        chk("s2_wb5_v", 32'(wb_valid), 32'h1);
        chk("s2_wb5_rd", 32'(wb_rd), 32'h5);
        chk("s2_pend_end", 32'(pending), 32'h0000);

        // rs2 checked for SUB, ignored for LOAD; flush leaves no trace
        drv(1, OPC_ADD, 4'd7, 4'd0, 4'd0);
        step();
        drv(1, OPC_SUB, 4'd9, 4'd0, 4'd7);
        chk("s3_sub_rs2_stall", 32'(stall), 32'h1);
        drv(1, OPC_LOAD, 4'd2, 4'd0, 4'd7);
        flush = 1'b1;
        #1;
        chk("s3_flush_issue", 32'(issue), 32'h0);
        chk("s3_flush_stall", 32'(stall), 32'h0);
        flush = 1'b0;
        #1;
        chk("s3_load_issue", 32'(issue), 32'h1);
        chk("s3_load_stall", 32'(stall), 32'h0);
        step();
        chk("s3_pend", 32'(pending), 32'h0084);
        idle();
        step();
        chk("s3_wb7", 32'(wb_rd), 32'h7);
        step();
        chk("s3_wb2", 32'(wb_rd), 32'h2);
        chk("s3_pend_end", 32'(pending), 32'h0000);
        step();

        // WAW on r3 with same-cycle retire and reissue
        drv(1, OPC_ADD, 4'd3, 4'd0, 4'd0);
        step();
        drv(1, OPC_ADD, 4'd3, 4'd0, 4'd0);
        chk("s4_waw_stall", 32'(stall), 32'h1);
        step();
        chk("s4_waw_issue", 32'(issue), 32'h1);
        step();
        chk("s4_pend_keep", 32'(pending), 32'h0008);
        chk("s4_wb_a", 32'({wb_valid, wb_rd}), 32'h13);
        idle();
        step();
        chk("s4_wb_gap", 32'(wb_valid), 32'h0);
        step();
        chk("s4_wb_b", 32'({wb_valid, wb_rd}), 32'h13);
        chk("s4_pend_end", 32'(pending), 32'h0000);
        step();
        chk("s4_wb_done", 32'(wb_valid), 32'h0);

        // Drain with two writers in flight
        drv(1, OPC_ADD, 4'd1, 4'd2, 4'd3);
        step();
        drv(1, OPC_SUB, 4'd4, 4'd5, 4'd6);
        step();
        idle();
        drain_req = 1'b1;
        step();
        chk("s5_wb1", 32'({wb_valid, wb_rd}), 32'h11);
        chk("s5_drained_a", 32'(drained), 32'h0);
        drv(1, OPC_ADD, 4'd10, 4'd0, 4'd0);
        chk("s5_drain_noissue", 32'(issue), 32'h0);
        chk("s5_drain_stall", 32'(stall), 32'h1);
        step();
        chk("s5_wb4", 32'({wb_valid, wb_rd}), 32'h14);
        chk("s5_pend0", 32'(pending), 32'h0);
        chk("s5_drained_b", 32'(drained), 32'h0);
        chk("s5_cnt_forced0", 32'(stall_cnt), 32'h0);
        step();
        chk("s5_drained_c", 32'(drained), 32'h1);
        chk("s5_halt_noissue", 32'(issue), 32'h0);
        drain_req = 1'b0;
        #1;
        chk("s5_halt_stall", 32'(stall), 32'h1);
        step();
        chk("s5_drained_off", 32'(drained), 32'h0);
        chk("s5_resume_issue", 32'(issue), 32'h1);
        step();
        chk("s5_pend_r10", 32'(pending), 32'h0400);
        idle();
        step();
        step();
        chk("s5_wb10", 32'({wb_valid, wb_rd}), 32'h1a);

        // Asynchronous reset mid-flight
        drv(1, OPC_ADD, 4'd1, 4'd2, 4'd3);
        step();
        drv(1, OPC_SUB, 4'd4, 4'd5, 4'd6);
        step();
        chk("s6_pend_pre", 32'(pending), 32'h0012);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_pend", 32'(pending), 32'h0);
        chk("s6_rst_outs", 32'({wb_valid, drained, err, stall_cnt}), 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s6_no_wb", 32'(wb_valid), 32'h0);
        end

        // Watchdog: a stuck pending bit holds a writer in stall
        force dut.pend_q = 16'h0020;
        drv(1, OPC_ADD, 4'd6, 4'd5, 4'd0);
        chk("s7_stall", 32'(stall), 32'h1);
        repeat (6) step();
        chk("s7_cnt6", 32'(stall_cnt), 32'h6);
        chk("s7_err_before", 32'(err), 32'h0);
        step();
        chk("s7_cnt7", 32'(stall_cnt), 32'h7);
        chk("s7_err_set", 32'(err), 32'h1);
        repeat (8) step();
        chk("s7_cnt15", 32'(stall_cnt), 32'hf);
        step();
        chk("s7_cnt_sat", 32'(stall_cnt), 32'hf);
        idle();
        release dut.pend_q;
        step();
        chk("s7_cnt_clear", 32'(stall_cnt), 32'h0);
        chk("s7_err_sticky", 32'(err), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
